stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter NSTAGES, default 6, meaning the stage count and the width of the one-hot stage vector.
REQ-002 The block SHALL have parameter PASS_W, default 4, meaning the width of the pass-count input and of the pass index.
REQ-003 The block SHALL have parameter DWELL_W, default 4, meaning the width of the dwell input (cycles spent per stage).
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req, input, 1 bit: run request, level.
REQ-007 Port num_passes, input, PASS_W bits: passes over all stages; sampled only at accept.
REQ-008 Port dwell, input, DWELL_W bits: cycles per stage; sampled only at accept.
REQ-009 Port hold, input, 1 bit: freezes stage advance.
REQ-010 Port abort, input, 1 bit: terminates the run.
REQ-011 Port ack, output, 1 bit: one-cycle accept pulse.
REQ-012 Port busy, output, 1 bit: a run is active.
REQ-013 Port stage, output, NSTAGES bits: one-hot active stage, or all-zero when no stage is active.
REQ-014 Port pass_idx, output, PASS_W bits: current pass, zero-based.
REQ-015 Port last, output, 1 bit: high during the final stage of the final pass.
REQ-016 Port done, output, 1 bit: one-cycle completion pulse.
REQ-017 Port aborted, output, 1 bit: one-cycle abort pulse.

Function
REQ-018 The block SHALL implement the FSM states IDLE, RUN and DONE, with every output registered.
REQ-019 In IDLE, when req=1 and abort=0 are sampled at an edge, the block SHALL latch num_passes and dwell and enter RUN.
REQ-020 On entering RUN, the next cycle SHALL show ack=1, busy=1, stage=000001, pass_idx=0 and the dwell counter=0.
REQ-021 The latched num_passes=0 SHALL be treated as 1, and the latched dwell=0 SHALL be treated as 1.
REQ-022 In RUN with hold=0, the dwell counter SHALL increment each cycle.
REQ-023 When the dwell counter reaches dwell-1, the counter SHALL clear and stage SHALL rotate left by one bit on the next edge.
REQ-024 While hold=1, the stage value and the dwell counter SHALL hold their values; busy SHALL stay 1.
REQ-025 On expiry of the top stage bit when pass_idx < passes-1, stage SHALL wrap to 000001 and pass_idx SHALL increment.
REQ-026 On expiry of the top stage bit when pass_idx = passes-1, the block SHALL enter DONE.
REQ-027 In DONE (exactly one cycle), outputs SHALL be done=1, busy=0 and stage=0; the next state SHALL be IDLE.
REQ-028 A req sampled while in DONE SHALL NOT be accepted.
REQ-029 An uninterrupted run SHALL occupy passes*NSTAGES*dwell cycles in RUN, plus one cycle for each cycle that hold=1.
REQ-030 last SHALL equal stage[NSTAGES-1] AND (pass_idx = passes-1), registered and aligned with stage.
REQ-031 Abort=1 in RUN SHALL give, on the next cycle: IDLE state, aborted=1, busy=0, stage=0, pass_idx=0, and no done pulse.
REQ-032 Abort=1 SHALL take priority over hold, over stage expiry and over the final-stage transition.
REQ-033 Abort=1 sampled in IDLE or DONE SHALL be ignored and SHALL NOT produce an aborted pulse.
REQ-034 In IDLE, when req=1 and abort=1 are sampled together, the request SHALL NOT be accepted.
REQ-035 After any accept, req SHALL be ignored until the state is IDLE again.
REQ-036 A req still held high on return to IDLE SHALL start a new run at the next edge.
REQ-037 ack, done and aborted SHALL be mutually exclusive and each SHALL be exactly one cycle wide.

Reset
REQ-038 Assertion of rst=0 SHALL immediately, without a clock, force: IDLE, ack=0, busy=0, stage=0, pass_idx=0, last=0, done=0, aborted=0, and all latched configuration and counters to 0.
REQ-039 Reset asserted mid-run SHALL discard the run and SHALL produce no done or aborted pulse.
REQ-040 After rst rises, the first accept SHALL occur no earlier than the first rising edge of clk.

Verification
REQ-041 Scenario: passes=1, dwell=1, req at edge 0 -> ack at cycle 1; stage 000001..100000 over cycles 1-6; last=1 at cycle 6; done=1 at cycle 7; busy=0 from cycle 7.
REQ-042 Scenario: passes=2, dwell=3 -> each stage is held 3 cycles; pass_idx=0 for cycles 1-18 and 1 for cycles 19-36; stage wraps to 000001 at cycle 19; done at cycle 37.
REQ-043 Scenario: passes=1, dwell=2, with hold=1 for 4 cycles while stage=000100 -> stage is frozen during hold; done moves from cycle 13 to cycle 17.
REQ-044 Scenario: passes=3, dwell=2, abort during pass 1 at stage 001000 -> next cycle shows aborted=1, stage=0, busy=0, no done; a req held high is accepted one cycle later.
REQ-045 Scenario: passes=0, dwell=0 -> behaves identically to passes=1, dwell=1; in addition, req and abort sampled together in IDLE -> no ack.
REQ-046 Scenario: rst=0 driven between clock edges during pass 1 -> all outputs are 0 immediately; no done or aborted pulse follows release of rst.

Source files
------------

// File: rtl/stage_sequencer.sv
// Stage sequencer: walks a one-hot stage vector for a configurable number of
// passes, dwelling a configurable number of cycles per stage, with hold and abort.
module stage_sequencer #(
  parameter int NSTAGES = 6,
  parameter int PASS_W  = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [PASS_W-1:0]  num_passes,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               hold,
  input  logic               abort,
  output logic               ack,
  output logic               busy,
  output logic [NSTAGES-1:0] stage,
  output logic [PASS_W-1:0]  pass_idx,
  output logic               last,
  output logic               done,
  output logic               aborted
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PASS_W-1:0]  passes_q, passes_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NSTAGES-1:0] stage_q, stage_d;
  logic [PASS_W-1:0]  pidx_q, pidx_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      passes_q  <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      stage_q   <= '0;
      pidx_q    <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      passes_q  <= passes_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      pidx_q    <= pidx_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    passes_d  = passes_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    pidx_d    = pidx_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !abort) begin
          state_d  = RUN;
          // zero-valued configuration runs as one pass / one cycle per stage
          passes_d = (num_passes == '0) ? PASS_W'(1) : num_passes;
          dwell_d  = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_d    = '0;
          stage_d  = NSTAGES'(1);
          pidx_d   = '0;
          ack_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          busy_d    = 1'b0;
          stage_d   = '0;
          pidx_d    = '0;
          cnt_d     = '0;
        end else if (!hold) begin
          if (cnt_q == dwell_q - DWELL_W'(1)) begin
            cnt_d = '0;
            if (stage_q[NSTAGES-1]) begin
              if (pidx_q == passes_q - PASS_W'(1)) begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stage_d = '0;
                pidx_d  = '0;
              end else begin
                stage_d = NSTAGES'(1);
                pidx_d  = pidx_q + PASS_W'(1);
              end
            end else begin
              stage_d = {stage_q[NSTAGES-2:0], stage_q[NSTAGES-1]};
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // computed from next-state values so it lines up with the registered stage
    last_d = stage_d[NSTAGES-1] && (pidx_d == passes_d - PASS_W'(1));
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign stage    = stage_q;
  assign pass_idx = pidx_q;
  assign last     = last_q;
  assign done     = done_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: normal runs, hold, abort, zero config, reset.
module tb_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst, req, hold, abort;
  logic [3:0] num_passes, dwell;
  logic       ack, busy, last, done, aborted;
  logic [5:0] stage;
  logic [3:0] pass_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  stage_sequencer #(.NSTAGES(6), .PASS_W(4), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .num_passes(num_passes), .dwell(dwell),
    .hold(hold), .abort(abort), .ack(ack), .busy(busy), .stage(stage),
    .pass_idx(pass_idx), .last(last), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ev(input logic a, input logic b, input logic [5:0] st,
                                     input logic [3:0] p, input logic l, input logic d,
                                     input logic ab);
    return {17'd0, a, b, st, p, l, d, ab};
  endfunction

  function automatic logic [31:0] outs();
    return {17'd0, ack, busy, stage, pass_idx, last, done, aborted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Checks every RUN cycle from the ack cycle through done and the following idle cycle.
  task automatic run_expect(input int np, input int dw, input int done_cyc, input string tag);
    for (int p = 0; p < np; p++)
      for (int s = 0; s < 6; s++)
        for (int d = 0; d < dw; d++) begin
          chk($sformatf("%s_p%0d_s%0d_d%0d", tag, p, s, d), outs(),
              ev((p == 0 && s == 0 && d == 0), 1'b1, 6'b1 << s, 4'(p),
                 (s == 5 && p == np - 1), 1'b0, 1'b0));
          tick();
        end
    chk({tag, "_done"}, outs(), ev(0, 0, 6'd0, 4'd0, 0, 1, 0));
    chk({tag, "_done_cycle"}, cyc, done_cyc);
    tick();
    chk({tag, "_idle"}, outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));
  endtask

  initial begin
    req = 0; hold = 0; abort = 0; num_passes = 0; dwell = 0;
    rst = 1;
    #1 rst = 0;
    #2 chk("reset_state", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));
    @(negedge clk) rst = 1;

    // passes=1 dwell=1: done at cycle 7
    num_passes = 1; dwell = 1; req = 1; cyc = 0;
    tick(); req = 0;
    run_expect(1, 1, 7, "s1");

    // passes=2 dwell=3: wrap at 19, done at 37
    num_passes = 2; dwell = 3; req = 1; cyc = 0;
    tick(); req = 0;
    run_expect(2, 3, 37, "s2");

    // passes=1 dwell=2 with hold sampled at edges 5..8 while stage=000100
    num_passes = 1; dwell = 2; req = 1; cyc = 0;
    tick(); req = 0;
    for (int c = 1; c <= 16; c++) begin
      int e;
      e = (c <= 4) ? c : ((c <= 8) ? 5 : c - 4);
      chk($sformatf("s3_c%0d", c), outs(),
          ev(c == 1, 1'b1, 6'b1 << ((e - 1) / 2), 4'd0, ((e - 1) / 2) == 5, 1'b0, 1'b0));
      hold = (c >= 5 && c <= 8);
      tick();
    end
    chk("s3_done", outs(), ev(0, 0, 6'd0, 4'd0, 0, 1, 0));
    chk("s3_done_cycle", cyc, 17);
    tick();

    // passes=3 dwell=2, req held through the run, abort at stage 001000 of pass 1
    num_passes = 3; dwell = 2; req = 1; cyc = 0;
    tick();
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("s4_c%0d", c), outs(),
          ev(c == 1, 1'b1, 6'b1 << (((c - 1) % 12) / 2), 4'((c - 1) / 12), 1'b0, 1'b0, 1'b0));
      if (c < 19) tick();
    end
    abort = 1;
    tick();
    chk("s4_aborted", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 1));
    abort = 0;
    tick();
    chk("s4_reaccept", outs(), ev(1, 1, 6'd1, 4'd0, 0, 0, 0));
    abort = 1; hold = 1; req = 0;
    tick();
    chk("s4_abort_over_hold", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 1));
    hold = 0;
    tick();
    chk("s4_abort_idle_ignored", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));
    req = 1;
    tick();
    chk("s5_req_abort_no_ack", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));

    // passes=0 dwell=0 behaves as 1/1; req held high across DONE
    abort = 0; num_passes = 0; dwell = 0; cyc = 0;
    tick();
    run_expect(1, 1, 7, "s5");
    tick();
    chk("s5_rerun_ack", outs(), ev(1, 1, 6'd1, 4'd0, 0, 0, 0));
    req = 0; abort = 1;
    tick();
    chk("s5_abort", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 1));
    abort = 0;

    // asynchronous reset in pass 1
    num_passes = 2; dwell = 1; req = 1; cyc = 0;
    tick(); req = 0;
    repeat (7) tick();
    chk("s6_pre_reset", outs(), ev(0, 1, 6'b000010, 4'd1, 0, 0, 0));
    #2 rst = 0;
    #1 chk("s6_async_reset", outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));
    #2 rst = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("s6_post_%0d", k), outs(), ev(0, 0, 6'd0, 4'd0, 0, 0, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
